// File: rtl/audio_clk_pkg.sv
// -----------------------------------------------------------------------------
// audio_clk_pkg
// Shared definitions for the audio-PLL reset sequencer:
//   - seq_state_e : sequencer FSM states
//   - DEF_*       : default timing constants (in clk cycles)
//   - cnt_width() : width of the shared down-counter for a given timing set
// No ports (package).
// -----------------------------------------------------------------------------
package audio_clk_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_HOLD,
        ST_STAGGER,
        ST_RUN
    } seq_state_e;

    localparam int DEF_LOCK_STABLE_CYC = 1024;
    localparam int DEF_RST_HOLD_CYC    = 16;
    localparam int DEF_STAGE_GAP_CYC   = 8;

    // The largest value ever loaded is below max(a, b, c), so $clog2 of the
    // maximum is always wide enough; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_LOCK_STABLE_CYC, DEF_RST_HOLD_CYC,
                                         DEF_STAGE_GAP_CYC);

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk_i - destination clock
//   rst_i - synchronous active-high reset, clears every stage
//   d_i   - asynchronous input
//   q_o   - synchronised output (last flop)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq
// Reset sequencer behind the audio PLL. Synchronises pll_lock, qualifies it
// for LOCK_STABLE_CYC cycles, holds both resets RST_HOLD_CYC more cycles,
// releases the codec reset, then the DSP reset STAGE_GAP_CYC cycles later.
// Loss of lock in STAGGER/RUN reasserts both resets and is logged.
// Ports:
//   clk              - PLL output clock (only clock)
//   rst              - synchronous active-high reset
//   pll_lock         - raw PLL lock, asynchronous
//   sticky_clr       - one-cycle clear of lock_loss_sticky
//   codec_rst_out    - active-high codec/I2S reset
//   dsp_rst_out      - active-high FFT/FIR reset
//   rst_released     - high only in RUN
//   lock_loss_sticky - set on any counted lock loss
//   lock_loss_cnt    - saturating lock-loss count
// -----------------------------------------------------------------------------
module pll_rst_seq
    import audio_clk_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int RST_HOLD_CYC    = DEF_RST_HOLD_CYC,
    parameter int STAGE_GAP_CYC   = DEF_STAGE_GAP_CYC,
    parameter int LOSS_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    input  logic                  sticky_clr,
    output logic                  codec_rst_out,
    output logic                  dsp_rst_out,
    output logic                  rst_released,
    output logic                  lock_loss_sticky,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int CNT_W = cnt_width(LOCK_STABLE_CYC, RST_HOLD_CYC, STAGE_GAP_CYC);

    // The WAIT_LOCK->STABLE edge already consumes one lock_s=1 sample, so
    // STABLE loads two less than the qualification length; a load of N-1
    // gives N cycles before the expiry edge.
    localparam logic [CNT_W-1:0] LOAD_STABLE = CNT_W'(LOCK_STABLE_CYC - 2);
    localparam logic [CNT_W-1:0] LOAD_HOLD   = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_GAP    = CNT_W'(STAGE_GAP_CYC - 1);

    logic                  lock_s;
    logic                  lock_lost;
    seq_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  codec_rst_q;
    logic                  dsp_rst_q;
    logic                  released_q;
    logic                  sticky_q;
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    // Only losses after the codec has come out of reset are counted.
    assign lock_lost = ((state_q == ST_STAGGER) || (state_q == ST_RUN)) && !lock_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            codec_rst_q <= 1'b1;
            dsp_rst_q   <= 1'b1;
            released_q  <= 1'b0;
            sticky_q    <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= ST_STABLE;
                        cnt_q   <= LOAD_STABLE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_q <= ST_WAIT_LOCK;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= LOAD_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        state_q <= ST_WAIT_LOCK;
                    end else if (cnt_q == '0) begin
                        state_q     <= ST_STAGGER;
                        cnt_q       <= LOAD_GAP;
                        codec_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_STAGGER: begin
                    if (!lock_s) begin
                        state_q     <= ST_WAIT_LOCK;
                        codec_rst_q <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q    <= ST_RUN;
                        dsp_rst_q  <= 1'b0;
                        released_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_q     <= ST_WAIT_LOCK;
                        codec_rst_q <= 1'b1;
                        dsp_rst_q   <= 1'b1;
                        released_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_WAIT_LOCK;
                    codec_rst_q <= 1'b1;
                    dsp_rst_q   <= 1'b1;
                    released_q  <= 1'b0;
                end
            endcase

            // A loss in the same cycle as a clear keeps the flag set.
            if (lock_lost) begin
                sticky_q <= 1'b1;
            end else if (sticky_clr) begin
                sticky_q <= 1'b0;
            end

            if (lock_lost && (loss_cnt_q != '1)) begin
                loss_cnt_q <= loss_cnt_q + 1'b1;
            end
        end
    end

    assign codec_rst_out    = codec_rst_q;
    assign dsp_rst_out      = dsp_rst_q;
    assign rst_released     = released_q;
    assign lock_loss_sticky = sticky_q;
    assign lock_loss_cnt    = loss_cnt_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_seq
// Directed + randomised bench for pll_rst_seq. The reference model tracks how
// many consecutive clock edges the sequencer has seen a synchronised lock, and
// derives every output from that run length.
// -----------------------------------------------------------------------------
module tb_pll_rst_seq;

    localparam int SS  = 2;
    localparam int LSC = 8;
    localparam int RHC = 4;
    localparam int SGC = 2;
    localparam int W   = 2;

    localparam int REL_CODEC = LSC + RHC;        // run length at codec release
    localparam int REL_DSP   = LSC + RHC + SGC;  // run length at dsp release
    localparam int CNT_MAX   = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         pll_lock;
    logic         sticky_clr;
    logic         codec_rst_out;
    logic         dsp_rst_out;
    logic         rst_released;
    logic         lock_loss_sticky;
    logic [W-1:0] lock_loss_cnt;

    pll_rst_seq #(
        .SYNC_STAGES     (SS),
        .LOCK_STABLE_CYC (LSC),
        .RST_HOLD_CYC    (RHC),
        .STAGE_GAP_CYC   (SGC),
        .LOSS_CNT_W      (W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pll_lock         (pll_lock),
        .sticky_clr       (sticky_clr),
        .codec_rst_out    (codec_rst_out),
        .dsp_rst_out      (dsp_rst_out),
        .rst_released     (rst_released),
        .lock_loss_sticky (lock_loss_sticky),
        .lock_loss_cnt    (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    int total = 0;
    int bad   = 0;
    int k     = 0;      // consecutive edges at which the FSM saw lock_s=1
    int cnt_m = 0;
    bit sticky_m = 1'b0;
    bit sync_m [SS];

    function automatic void model_edge();
        bit seen;
        bit loss;
        seen = sync_m[SS-1];
        if (rst) begin
            k = 0;
            cnt_m = 0;
            sticky_m = 1'b0;
            for (int i = 0; i < SS; i++) sync_m[i] = 1'b0;
        end else begin
            loss = !seen && (k >= REL_CODEC);
            for (int i = SS-1; i > 0; i--) sync_m[i] = sync_m[i-1];
            sync_m[0] = pll_lock;
            if (seen) k = (k < 100) ? k + 1 : k;
            else      k = 0;
            if (loss) begin
                sticky_m = 1'b1;
                cnt_m = (cnt_m < CNT_MAX) ? cnt_m + 1 : cnt_m;
            end else if (sticky_clr) begin
                sticky_m = 1'b0;
            end
        end
    endfunction

    task automatic check_outputs();
        logic         e_codec;
        logic         e_dsp;
        logic         e_rel;
        logic [W-1:0] e_cnt;
        e_codec = (k < REL_CODEC);
        e_dsp   = (k < REL_DSP);
        e_rel   = (k >= REL_DSP);
        e_cnt   = W'(cnt_m);

        total++;
        assert (codec_rst_out === e_codec) else begin
            bad++;
            $error("FAIL codec_rst_out t=%0t observed=%b expected=%b", $time, codec_rst_out, e_codec);
        end
        total++;
        assert (dsp_rst_out === e_dsp) else begin
            bad++;
            $error("FAIL dsp_rst_out t=%0t observed=%b expected=%b", $time, dsp_rst_out, e_dsp);
        end
        total++;
        assert (rst_released === e_rel) else begin
            bad++;
            $error("FAIL rst_released t=%0t observed=%b expected=%b", $time, rst_released, e_rel);
        end
        total++;
        assert (lock_loss_sticky === sticky_m) else begin
            bad++;
            $error("FAIL lock_loss_sticky t=%0t observed=%b expected=%b", $time, lock_loss_sticky, sticky_m);
        end
        total++;
        assert (lock_loss_cnt === e_cnt) else begin
            bad++;
            $error("FAIL lock_loss_cnt t=%0t observed=%0d expected=%0d", $time, lock_loss_cnt, e_cnt);
        end
        total++;
        assert (!(dsp_rst_out === 1'b0 && codec_rst_out !== 1'b0)) else begin
            bad++;
            $error("FAIL rst_order t=%0t observed codec=%b dsp=%b expected dsp held while codec in reset",
                   $time, codec_rst_out, dsp_rst_out);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int target;
        int len;

        for (int i = 0; i < SS; i++) sync_m[i] = 1'b0;
        rst        = 1'b1;
        pll_lock   = 1'b0;
        sticky_clr = 1'b0;

        // Reset state
        run(3);
        rst = 1'b0;

        // Clean lock from cycle 5
        run(4);
        pll_lock = 1'b1;
        run(REL_DSP + SS + 6);

        // Loss in RUN for 3 cycles, then full re-sequence
        pll_lock = 1'b0;
        run(3);
        pll_lock = 1'b1;
        run(REL_DSP + SS + 4);

        // Unstable lock from a clean reset: 5 high, 1 low, then high
        rst = 1'b1;
        pll_lock = 1'b0;
        run(2);
        rst = 1'b0;
        run(2);
        pll_lock = 1'b1;
        run(5);
        pll_lock = 1'b0;
        run(1);
        pll_lock = 1'b1;
        run(REL_DSP + SS + 4);

        // Four losses in RUN; clear requested in the same cycle as the fourth
        for (int i = 0; i < 4; i++) begin
            pll_lock = 1'b1;
            target = REL_DSP + int'($urandom_range(0, 5));
            for (int j = 0; j < 60 && k < target; j++) tick();
            pll_lock = 1'b0;
            for (int j = 0; j < SS + 3; j++) begin
                sticky_clr = (i == 3) && !sync_m[SS-1] && (k >= REL_CODEC);
                tick();
            end
            sticky_clr = 1'b0;
        end
        run(2);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        run(2);

        // Loss during STAGGER
        pll_lock = 1'b1;
        for (int j = 0; j < 60 && k != REL_CODEC - SS + 1; j++) tick();
        pll_lock = 1'b0;
        run(4);
        pll_lock = 1'b1;
        run(REL_DSP + SS + 3);

        // One-cycle rst during HOLD restarts qualification
        pll_lock = 1'b0;
        run(3);
        pll_lock = 1'b1;
        for (int j = 0; j < 60 && k != LSC + 1; j++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(REL_DSP + SS + 4);

        // Sub-period glitch in RUN that no edge samples
        #2 pll_lock = 1'b0;
        #2 pll_lock = 1'b1;
        run(4);

        // Randomised segments
        for (int seg = 0; seg < 40; seg++) begin
            pll_lock   = 1'($urandom_range(0, 1));
            sticky_clr = ($urandom_range(0, 7) == 0);
            rst        = ($urandom_range(0, 29) == 0);
            len = pll_lock ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 4));
            tick();
            sticky_clr = 1'b0;
            rst        = 1'b0;
            run(len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
